// File: rtl/lbus_blk_pkg.sv
// lbus_blk_pkg: local-bus address map, ID value, FSM state encoding and STATUS bit
// positions shared by the lbus_blk_if slice.
package lbus_blk_pkg;

  localparam logic [15:0] ADDR_CTRL   = 16'h0002;
  localparam logic [15:0] ADDR_STATUS = 16'h0004;
  localparam logic [15:0] ADDR_CYCCNT = 16'h0006;
  localparam logic [15:0] ADDR_ENCDEC = 16'h000C;
  localparam logic [15:0] ADDR_KEY    = 16'h0100;
  localparam logic [15:0] ADDR_DIN    = 16'h0140;
  localparam logic [15:0] ADDR_DOUT   = 16'h0180;
  localparam logic [15:0] ADDR_ID     = 16'hFFFC;

  localparam logic [15:0] ID_VALUE    = 16'h4703;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_TMO  = 2;
  localparam int STAT_OVR  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DLY  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/lbus_wr_edge.sv
// lbus_wr_edge: two-flop synchroniser for the asynchronous write strobe, followed by a
// rising-edge detector that emits a registered one-cycle pulse.
module lbus_wr_edge (
  input  logic clk,
  input  logic rst,
  input  logic wr_i,
  output logic wstb_o
);

  // sync_q[1] is the synchronised level; sync_q[2] is its previous value
  logic [2:0] sync_q;
  logic       wstb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      wstb_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], wr_i};
      wstb_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign wstb_o = wstb_q;

endmodule

// File: rtl/lbus_blk_if.sv
// lbus_blk_if: local-bus register front end for a block-cipher core (key/din load, start,
// result readback). Define LBUS_CYCCNT_EN to build the RUN cycle counter readable at 0x0006.
module lbus_blk_if
  import lbus_blk_pkg::*;
#(
  parameter int KEY_W    = 256,
  parameter int DATA_W   = 128,
  parameter int TRIG_DLY = 3,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       lbus_a,
  input  logic [15:0]       lbus_di,
  input  logic              lbus_wr,
  input  logic              lbus_rd,
  output logic [15:0]       lbus_do,
  output logic [KEY_W-1:0]  blk_kin,
  output logic [DATA_W-1:0] blk_din,
  input  logic [DATA_W-1:0] blk_dout,
  output logic              blk_krdy,
  output logic              blk_drdy,
  input  logic              blk_kvld,
  input  logic              blk_dvld,
  output logic              blk_encdec,
  output logic              blk_en,
  output logic              blk_rstn,
  output logic              blk_busy
);

  localparam int KW = KEY_W / 16;
  localparam int DW = DATA_W / 16;

  state_e      state_q, state_d;
  logic [3:0]  dly_q, dly_d;
  logic [15:0] tmo_q, tmo_d;
  logic        drdy_q, drdy_d, rstn_q, rstn_d;
  logic        done_q, done_d, tmo_flag_q, tmo_flag_d, ovr_q, ovr_d;
  logic        krdy_q, key_busy_q, encdec_q, cap_dout;
  logic [15:0] key_q  [KW];
  logic [15:0] din_q  [DW];
  logic [15:0] dout_q [DW];
  logic [15:0] do_q, rd_data_d, cyc_rd;
  logic        wstb, busy, wr_ctrl, start_req, rd_status;

  lbus_wr_edge u_wr_edge (
    .clk    (clk),
    .rst    (rst),
    .wr_i   (lbus_wr),
    .wstb_o (wstb)
  );

  assign busy      = (state_q != S_IDLE);
  assign wr_ctrl   = wstb && (lbus_a == ADDR_CTRL);
  assign start_req = wr_ctrl && lbus_di[0];
  assign rd_status = !lbus_rd && (lbus_a == ADDR_STATUS);

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    tmo_d      = tmo_q;
    drdy_d     = 1'b0;
    rstn_d     = 1'b1;
    cap_dout   = 1'b0;
    done_d     = done_q;
    tmo_flag_d = tmo_flag_q;
    ovr_d      = rd_status ? 1'b0 : ovr_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          done_d     = 1'b0;
          tmo_flag_d = 1'b0;
          tmo_d      = '0;
          // The strobe cycle itself counts toward the delay, so DLY lasts TRIG_DLY-1 cycles
          if (TRIG_DLY == 1) begin
            state_d = S_RUN;
            drdy_d  = 1'b1;
          end else begin
            state_d = S_DLY;
            dly_d   = 4'(TRIG_DLY - 2);
          end
        end
      end
      S_DLY: begin
        if (dly_q == '0) begin
          state_d = S_RUN;
          drdy_d  = 1'b1;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      S_RUN: begin
        if (blk_dvld) begin
          state_d  = S_IDLE;
          cap_dout = 1'b1;
          done_d   = 1'b1;
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          state_d    = S_IDLE;
          tmo_flag_d = 1'b1;
          rstn_d     = 1'b0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start_req && busy) ovr_d = 1'b1;
    // Core reset overrides any completion or start seen in the same cycle
    if (wr_ctrl && lbus_di[2]) begin
      state_d  = S_IDLE;
      rstn_d   = 1'b0;
      drdy_d   = 1'b0;
      cap_dout = 1'b0;
      done_d   = done_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dly_q      <= '0;
      tmo_q      <= '0;
      drdy_q     <= 1'b0;
      rstn_q     <= 1'b1;
      done_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      tmo_q      <= tmo_d;
      drdy_q     <= drdy_d;
      rstn_q     <= rstn_d;
      done_q     <= done_d;
      tmo_flag_q <= tmo_flag_d;
      ovr_q      <= ovr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      krdy_q     <= 1'b0;
      key_busy_q <= 1'b0;
      encdec_q   <= 1'b0;
      for (int i = 0; i < KW; i++) key_q[i] <= '0;
      for (int i = 0; i < DW; i++) din_q[i] <= '0;
      for (int i = 0; i < DW; i++) dout_q[i] <= '0;
    end else begin
      krdy_q <= wr_ctrl && lbus_di[1];
      if (blk_kvld) key_busy_q <= 1'b0;
      else if (wr_ctrl && lbus_di[1]) key_busy_q <= 1'b1;
      // Core inputs are frozen while a block is in flight
      if (wstb && !busy && lbus_a == ADDR_ENCDEC) encdec_q <= lbus_di[0];
      for (int i = 0; i < KW; i++)
        if (wstb && !busy && lbus_a == ADDR_KEY + 16'(2 * i)) key_q[i] <= lbus_di;
      for (int i = 0; i < DW; i++)
        if (wstb && !busy && lbus_a == ADDR_DIN + 16'(2 * i)) din_q[i] <= lbus_di;
      if (cap_dout)
        for (int i = 0; i < DW; i++) dout_q[i] <= blk_dout[DATA_W-1-16*i -: 16];
    end
  end

`ifdef LBUS_CYCCNT_EN
  logic [15:0] cyc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else if (state_q == S_IDLE && state_d != S_IDLE) cyc_q <= '0;
    else if (state_q == S_RUN && state_d == S_RUN && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
  end
  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

  always_comb begin
    rd_data_d = '0;
    case (lbus_a)
      ADDR_CTRL:   rd_data_d = {13'b0, ~rstn_q, key_busy_q, busy};
      ADDR_STATUS: begin
        rd_data_d[STAT_BUSY] = busy;
        rd_data_d[STAT_DONE] = done_q;
        rd_data_d[STAT_TMO]  = tmo_flag_q;
        rd_data_d[STAT_OVR]  = ovr_q;
      end
      ADDR_CYCCNT: rd_data_d = cyc_rd;
      ADDR_ENCDEC: rd_data_d = {15'b0, encdec_q};
      ADDR_ID:     rd_data_d = ID_VALUE;
      default:     rd_data_d = '0;
    endcase
    for (int i = 0; i < DW; i++)
      if (lbus_a == ADDR_DOUT + 16'(2 * i)) rd_data_d = dout_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) do_q <= '0;
    else if (!lbus_rd) do_q <= rd_data_d;
  end

  for (genvar gi = 0; gi < KW; gi++) begin : g_kin
    assign blk_kin[KEY_W-1-16*gi -: 16] = key_q[gi];
  end
  for (genvar gi = 0; gi < DW; gi++) begin : g_din
    assign blk_din[DATA_W-1-16*gi -: 16] = din_q[gi];
  end

  assign lbus_do    = do_q;
  assign blk_krdy   = krdy_q;
  assign blk_drdy   = drdy_q;
  assign blk_rstn   = rstn_q;
  assign blk_busy   = busy;
  assign blk_encdec = encdec_q;
  assign blk_en     = 1'b1;

endmodule

// File: tb/tb_lbus_blk_if.sv
// tb_lbus_blk_if: directed bench with a read scoreboard; a default instance plus a
// TIMEOUT=10 instance share the local bus so the abort path can be observed.
module tb_lbus_blk_if;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  lbus_a, lbus_di;
  logic         lbus_wr, lbus_rd;
  logic [15:0]  do0, do1;
  logic [255:0] kin0, kin1;
  logic [127:0] din0, din1;
  logic [127:0] dout_val;
  logic         krdy0, krdy1, drdy0, drdy1, kvld, dvld0, dvld1;
  logic         encdec0, encdec1, en0, en1, rstn0, rstn1, busy0, busy1;

  always #5 clk = ~clk;

  lbus_blk_if dut (
    .clk(clk), .rst(rst), .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wr(lbus_wr),
    .lbus_rd(lbus_rd), .lbus_do(do0), .blk_kin(kin0), .blk_din(din0), .blk_dout(dout_val),
    .blk_krdy(krdy0), .blk_drdy(drdy0), .blk_kvld(kvld), .blk_dvld(dvld0),
    .blk_encdec(encdec0), .blk_en(en0), .blk_rstn(rstn0), .blk_busy(busy0)
  );

  lbus_blk_if #(.TIMEOUT(10)) dut_t (
    .clk(clk), .rst(rst), .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wr(lbus_wr),
    .lbus_rd(lbus_rd), .lbus_do(do1), .blk_kin(kin1), .blk_din(din1), .blk_dout(dout_val),
    .blk_krdy(krdy1), .blk_drdy(drdy1), .blk_kvld(kvld), .blk_dvld(dvld1),
    .blk_encdec(encdec1), .blk_en(en1), .blk_rstn(rstn1), .blk_busy(busy1)
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
    bit          sel;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic rd_seen = 1'b0;

  int cyc = 0, wstb_cyc = 0, drdy_dist0 = -1, drdy_cyc1 = -1, rstn_cyc1 = -1;
  int drdy_n0 = 0, krdy_n0 = 0, rstn_lo0 = 0, rstn_lo1 = 0;

  logic [255:0] exp_key;
  logic [127:0] exp_din;
  logic [127:0] exp_dout;
  logic [15:0]  exp_cyc;
  int           save_drdy, save_rstn;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic lbus_write(input logic [15:0] a, input logic [15:0] d, input bit kv);
    bit got = 1'b0;
    lbus_a  = a;
    lbus_di = d;
    lbus_wr = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (dut.wstb) begin
        got = 1'b1;
        if (kv) kvld = 1'b1;
      end
    end
    if (!got) chk("wstb_seen", 0, 1);
    @(negedge clk);
    kvld    = 1'b0;
    lbus_wr = 1'b0;
    repeat (3) @(negedge clk);
    $display("wr a=%h d=%h", a, d);
  endtask

  task automatic lbus_read(input logic [15:0] a, input logic [15:0] e, input bit sel, input string nm);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    x.sel  = sel;
    sbq.push_back(x);
    lbus_a  = a;
    lbus_rd = 1'b0;
    @(negedge clk);
    lbus_rd = 1'b1;
    @(negedge clk);
  endtask

  always @(posedge clk) rd_seen <= !lbus_rd && !rst;

  // Monitor: pulse bookkeeping and scoreboard compare one cycle after each read
  always @(negedge clk) begin
    cyc++;
    if (dut.wstb) wstb_cyc = cyc;
    if (drdy0) begin
      if (drdy_n0 == 0) drdy_dist0 = cyc - wstb_cyc;
      drdy_n0++;
    end
    if (drdy1 && drdy_cyc1 < 0) drdy_cyc1 = cyc;
    if (krdy0) krdy_n0++;
    if (!rstn0) rstn_lo0++;
    if (!rstn1) begin
      if (rstn_cyc1 < 0) rstn_cyc1 = cyc;
      rstn_lo1++;
    end
    if (rd_seen) begin
      if (sbq.size() == 0) begin
        chk("unexpected_read", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        $display("rd %s -> %h", mon_e.name, mon_e.sel ? do1 : do0);
        chk(mon_e.name, mon_e.sel ? do1 : do0, mon_e.exp);
      end
    end
  end

  // Core model for the default instance: answer the first start 40 cycles after drdy
  initial begin
    dvld0 = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (drdy0) break;
    end
    repeat (40) @(negedge clk);
    dvld0 = 1'b1;
    @(negedge clk);
    dvld0 = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lbus_a = '0; lbus_di = '0; lbus_wr = 1'b0; lbus_rd = 1'b1;
    kvld = 1'b0; dvld1 = 1'b0;
    exp_dout = 128'h8EA2B7CA516745BFEAFC49904B496089;
    dout_val = exp_dout;
    for (int i = 0; i < 32; i++) exp_key = {exp_key[247:0], 8'(i)};
    for (int i = 0; i < 16; i++) exp_din = {exp_din[119:0], 8'(17 * i)};
`ifdef LBUS_CYCCNT_EN
    exp_cyc = 16'd40;
`else
    exp_cyc = 16'd0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_do", do0, 0);
    chk("rst_rstn", rstn0, 1);
    chk("rst_krdy", krdy0, 0);
    chk("rst_drdy", drdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_kin", kin0, 0);
    chk("rst_din", din0, 0);
    chk("rst_encdec", encdec0, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) lbus_write(16'h0100 + 16'(2 * i), {8'(2 * i), 8'(2 * i + 1)}, 1'b0);
    for (int i = 0; i < 8; i++) lbus_write(16'h0140 + 16'(2 * i), {8'(34 * i), 8'(34 * i + 17)}, 1'b0);
    chk("kin", kin0, exp_key);
    chk("din", din0, exp_din);

    lbus_write(16'h0002, 16'h0001, 1'b0);
    chk("drdy_latency", drdy_dist0, 3);
    lbus_write(16'h0100, 16'hDEAD, 1'b0);
    repeat (4) @(negedge clk);
    lbus_read(16'h0004, 16'h0001, 1'b0, "status_run");
    lbus_read(16'h0004, 16'h0004, 1'b1, "status_timeout");
    lbus_read(16'h0180, 16'h0000, 1'b1, "dout_after_timeout");
    chk("timeout_dist", rstn_cyc1 - drdy_cyc1, 10);
    chk("timeout_rstn_width", rstn_lo1, 1);

    lbus_write(16'h0002, 16'h0001, 1'b0);
    lbus_read(16'h0004, 16'h0009, 1'b0, "status_overrun");
    lbus_read(16'h0004, 16'h0001, 1'b0, "status_overrun_clr");
    chk("kin_frozen", kin0, exp_key);
    for (int k = 0; k < 200; k++) begin
      if (!busy0) break;
      @(negedge clk);
    end
    chk("run_end", busy0, 0);
    chk("drdy_count", drdy_n0, 1);
    lbus_read(16'h0004, 16'h0002, 1'b0, "status_done");
    for (int i = 0; i < 8; i++)
      lbus_read(16'h0180 + 16'(2 * i), exp_dout[127-16*i -: 16], 1'b0, $sformatf("dout%0d", i));
    lbus_read(16'h0006, exp_cyc, 1'b0, "cyccnt");
    lbus_read(16'h0002, 16'h0000, 1'b0, "ctrl_idle");

    lbus_write(16'h0002, 16'h0002, 1'b0);
    chk("krdy_pulse", krdy_n0, 1);
    lbus_read(16'h0002, 16'h0002, 1'b0, "key_busy_set");
    lbus_write(16'h0002, 16'h0002, 1'b1);
    chk("krdy_pulse2", krdy_n0, 2);
    lbus_read(16'h0002, 16'h0000, 1'b0, "key_busy_kvld");

    lbus_write(16'h000C, 16'h0001, 1'b0);
    chk("encdec_pin", encdec0, 1);
    lbus_read(16'h000C, 16'h0001, 1'b0, "encdec_rd");

    lbus_write(16'h0002, 16'h0001, 1'b0);
    lbus_write(16'h0002, 16'h0004, 1'b0);
    chk("core_rst_busy", busy0, 0);
    chk("core_rst_pulse", rstn_lo0, 1);
    chk("core_rst_drdy", drdy_n0, 2);
    lbus_read(16'h0004, 16'h0000, 1'b0, "status_core_rst");

    dout_val = 128'h0123456789ABCDEF0123456789ABCDEF;
    dvld0 = 1'b1;
    @(negedge clk);
    dvld0 = 1'b0;
    lbus_read(16'h0180, 16'h8EA2, 1'b0, "dout_idle_dvld");
    lbus_read(16'h0004, 16'h0000, 1'b0, "status_idle_dvld");

    lbus_read(16'h0008, 16'h0000, 1'b0, "unmapped");
    lbus_read(16'hFFFC, 16'h4703, 1'b0, "id");
    repeat (3) @(negedge clk);
    chk("do_hold", do0, 16'h4703);

    save_drdy = drdy_n0;
    save_rstn = rstn_lo0;
    lbus_a  = 16'h0002;
    lbus_di = 16'h0001;
    lbus_wr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dut.wstb) break;
    end
    @(negedge clk);
    chk("dly_entered", busy0, 1);
    rst = 1'b1;
    #1;
    chk("rst_abort_busy", busy0, 0);
    lbus_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_no_drdy", drdy_n0, save_drdy);
    chk("rst_no_rstn", rstn_lo0, save_rstn);
    chk("rst_kin_clr", kin0, 0);
    chk("rst_do_clr", do0, 0);
    chk("sb_drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
